sockit_ghrd_gpio_in_debounce: RTL and testbench

//  Parametrised Avalon-MM input PIO for board switches and buttons.
//  - Synchronises WIDTH raw inputs and debounces each bit.
//  - Captures rising and/or falling edges per bit, selected at run time.
//  - Raises a level IRQ to the HPS interrupt fabric.

---
 rtl/sockit_ghrd_gpio_in_debounce.sv | 160 ++++++++++++++++
 tb/tb_sockit_ghrd_gpio_in_debounce.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sockit_ghrd_gpio_in_debounce.sv
// rtl/sockit_ghrd_gpio_in_debounce.sv - debounced, edge-capturing input PIO with level IRQ
module sockit_ghrd_gpio_in_debounce #(
  parameter int                WIDTH           = 4,
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0]  RISE_RESET      = '1,
  parameter logic [WIDTH-1:0]  FALL_RESET      = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RAW     = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_RISE    = 3'd4;
  localparam logic [2:0] ADDR_FALL    = 3'd5;
  localparam logic [2:0] ADDR_PENDING = 3'd6;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] accept;

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] rise_ev, fall_ev;
  logic             unused_wdata;

  // Upper write-data bits beyond WIDTH have no storage behind them.
  assign unused_wdata = ^writedata;

  assign wr_en   = chipselect & ~write_n;
  assign wr_bits = writedata[WIDTH-1:0];
  assign sync_w  = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: raw pins are asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Per-bit debounce: accept a new level only after it differs for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_w[i] != stable_q[i]) begin
        if (cnt_q[i] >= CNT_MAX) begin
          stable_d[i] = sync_w[i];
          accept[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state: counters restart from zero whenever the input agrees with the accepted level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Edge events use the enables as they stand before any same-cycle register write.
  assign rise_ev  = accept &  sync_w & rise_q;
  assign fall_ev  = accept & ~sync_w & fall_q;
  assign clr_bits = (wr_en && address == ADDR_CAPTURE) ? wr_bits : '0;

  // Register writes; a new edge is OR-ed in after the W1C clear so it is never lost.
  always_comb begin
    mask_d    = mask_q;
    rise_d    = rise_q;
    fall_d    = fall_q;
    capture_d = (capture_q & ~clr_bits) | rise_ev | fall_ev;
    if (wr_en) begin
      case (address)
        ADDR_MASK: mask_d = wr_bits;
        ADDR_RISE: rise_d = wr_bits;
        ADDR_FALL: fall_d = wr_bits;
        default:   ;
      endcase
    end
  end

  // Read mux is evaluated every cycle from address alone; chipselect does not gate it.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = stable_q;
      ADDR_RAW:     readdata_d[WIDTH-1:0] = sync_w;
      ADDR_MASK:    readdata_d[WIDTH-1:0] = mask_q;
      ADDR_CAPTURE: readdata_d[WIDTH-1:0] = capture_q;
      ADDR_RISE:    readdata_d[WIDTH-1:0] = rise_q;
      ADDR_FALL:    readdata_d[WIDTH-1:0] = fall_q;
      ADDR_PENDING: readdata_d[WIDTH-1:0] = capture_q & mask_q;
      default:      readdata_d = '0;
    endcase
  end

  // Control/status registers and the registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q     <= '0;
      capture_q  <= '0;
      rise_q     <= RISE_RESET;
      fall_q     <= FALL_RESET;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      capture_q  <= capture_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(capture_q & mask_q);

endmodule

// File: tb/tb_sockit_ghrd_gpio_in_debounce.sv
// tb/tb_sockit_ghrd_gpio_in_debounce.sv - self-checking bench for the debounced input PIO
module tb_sockit_ghrd_gpio_in_debounce;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DC   = 4;
  localparam int HL   = SYNC + DC;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic [2:0]    address    = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = 32'd0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port    = '0;
  logic          irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sockit_ghrd_gpio_in_debounce #(
    .WIDTH           (W),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DC),
    .RISE_RESET      (4'hF),
    .FALL_RESET      (4'h0)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  // Reference model: samp[j] is the in_port value sampled j edges ago. A bit's accepted
  // level changes once the synchronised input has shown the other level for DC edges running.
  logic [W-1:0] samp [HL];
  logic [W-1:0] m_stable, m_mask, m_cap, m_rise, m_fall;
  logic [W-1:0] nstable, ev, clr;
  logic [31:0]  m_rd;
  logic         v, ok;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < HL; j++) samp[j] = '0;
      m_stable = '0;
      m_mask   = '0;
      m_cap    = '0;
      m_rise   = 4'hF;
      m_fall   = '0;
      m_rd     = '0;
    end else begin
      for (int j = HL - 1; j > 0; j--) samp[j] = samp[j-1];
      samp[0] = in_port;
      m_rd = '0;
      case (address)
        3'd0: m_rd[W-1:0] = m_stable;
        3'd1: m_rd[W-1:0] = samp[SYNC];
        3'd2: m_rd[W-1:0] = m_mask;
        3'd3: m_rd[W-1:0] = m_cap;
        3'd4: m_rd[W-1:0] = m_rise;
        3'd5: m_rd[W-1:0] = m_fall;
        3'd6: m_rd[W-1:0] = m_cap & m_mask;
        default: m_rd = '0;
      endcase
      ev = '0;
      nstable = m_stable;
      for (int i = 0; i < W; i++) begin
        v  = samp[SYNC][i];
        ok = 1'b1;
        for (int j = SYNC; j < HL; j++) if (samp[j][i] !== v) ok = 1'b0;
        if (ok && v !== m_stable[i]) begin
          nstable[i] = v;
          if (v ? m_rise[i] : m_fall[i]) ev[i] = 1'b1;
        end
      end
      clr = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
      m_cap = (m_cap & ~clr) | ev;
      if (chipselect && !write_n) begin
        case (address)
          3'd2: m_mask = writedata[W-1:0];
          3'd4: m_rise = writedata[W-1:0];
          3'd5: m_fall = writedata[W-1:0];
          default: ;
        endcase
      end
      m_stable = nstable;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(posedge clk) begin
    #2;
    chk("model_readdata", readdata, m_rd);
    chk("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic read_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #3;
    chk(nm, readdata, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    read_chk("rst_data", 3'd0, 32'h0);
    read_chk("rst_mask", 3'd2, 32'h0);
    read_chk("rst_capture", 3'd3, 32'h0);
    read_chk("rst_rise", 3'd4, 32'hF);
    read_chk("rst_fall", 3'd5, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);

    // Rising edge on bit 0, latency k+5, then W1C clear
    bus_write(3'd2, 32'h1);
    @(negedge clk);
    address = 3'd0; in_port = 4'b0001;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #3 chk("t2_irq_k4", {31'd0, irq}, 32'h0);
    @(posedge clk);
    #3 chk("t2_irq_k5", {31'd0, irq}, 32'h1);
    read_chk("t2_data", 3'd0, 32'h1);
    read_chk("t2_capture", 3'd3, 32'h1);
    bus_write(3'd3, 32'h1);
    read_chk("t2_capture_clr", 3'd3, 32'h0);
    chk("t2_irq_clr", {31'd0, irq}, 32'h0);

    // 3-cycle glitch on bit 1 is rejected; 4-cycle hold is accepted
    @(negedge clk);
    in_port = 4'b0011;
    repeat (3) @(negedge clk);
    in_port = 4'b0001;
    wait_cyc(8);
    read_chk("t3_glitch_data", 3'd0, 32'h1);
    read_chk("t3_glitch_capture", 3'd3, 32'h0);
    chk("t3_glitch_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    address = 3'd0; in_port = 4'b0011;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3 chk("t3_data_k5", readdata, 32'h1);
    @(posedge clk);
    #3 chk("t3_data_k6", readdata, 32'h3);
    bus_write(3'd3, 32'hF);

    // Fall-only capture on bit 2
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h4);
    bus_write(3'd2, 32'h4);
    @(negedge clk);
    in_port = 4'b0111;
    wait_cyc(8);
    read_chk("t4_rise_nocap", 3'd3, 32'h0);
    chk("t4_rise_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    in_port = 4'b0011;
    wait_cyc(8);
    read_chk("t4_fall_cap", 3'd3, 32'h4);
    chk("t4_fall_irq", {31'd0, irq}, 32'h1);
    read_chk("t4_pending", 3'd6, 32'h4);

    // W1C on bit 3 in the same cycle its rise is accepted: set wins
    bus_write(3'd3, 32'h4);
    bus_write(3'd4, 32'h8);
    @(negedge clk);
    in_port = 4'b1011;
    @(posedge clk);
    repeat (5) @(negedge clk);
    address = 3'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h8;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    @(posedge clk);
    #3 chk("t5_set_wins", readdata, 32'h8);
    read_chk("t5_data", 3'd0, 32'hB);

    // Reset mid-debounce with all capture bits set
    bus_write(3'd4, 32'hF);
    bus_write(3'd5, 32'hF);
    @(negedge clk);
    in_port = 4'b1100;
    wait_cyc(8);
    read_chk("t6_cap_all", 3'd3, 32'hF);
    bus_write(3'd2, 32'hF);
    chk("t6_irq_pre", {31'd0, irq}, 32'h1);
    @(negedge clk);
    address = 3'd0; in_port = 4'b1101;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("t6_irq_async", {31'd0, irq}, 32'h0);
    @(posedge clk);
    #3 chk("t6_readdata_rst", readdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3 chk("t6_data_p5", readdata, 32'h0);
    @(posedge clk);
    #3 chk("t6_data_p6", readdata, 32'hD);
    read_chk("t6_capture", 3'd3, 32'hD);
    read_chk("t6_mask", 3'd2, 32'h0);
    read_chk("t6_rise", 3'd4, 32'hF);
    read_chk("t6_fall", 3'd5, 32'h0);
    chk("t6_irq_post", {31'd0, irq}, 32'h0);

    wait_cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
